// File: rtl/posit_add_rr_sched.sv
// Round-robin front end that shares one pipelined raw posit adder among NREQ requesters.
// Optional grant counters: define POSIT_ARB_STATS_EN.
module posit_add_rr_sched #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RW         = 40,
  parameter int SW         = 42
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*RW-1:0]   req_in1,
  input  logic [NREQ*RW-1:0]   req_in2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*SW-1:0]   rsp_result,
  output logic [NREQ-1:0]      rsp_truncated,
  output logic [RW-1:0]        adder_in1,
  output logic [RW-1:0]        adder_in2,
  output logic                 adder_start,
  input  logic [SW-1:0]        adder_result,
  input  logic                 adder_done,
  input  logic                 adder_truncated,
  output logic                 sched_err,
  output logic [NREQ*32-1:0]   stat_grants
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(LATENCY + 1);

  // Handshake: requester i transfers an operand pair on any cycle where
  // req_valid[i] && req_ready[i]; consumer i takes the FIFO head on any cycle
  // where rsp_valid[i] && rsp_ready[i]. Neither side may depend on the other.
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] credit_q [NREQ];
  logic [IW-1:0] issue_id_q;
  logic          tag_v_q  [LATENCY];
  logic [IW-1:0] tag_id_q [LATENCY];
  logic [BW-1:0] blank_q;
  logic [AW-1:0] wr_q  [NREQ];
  logic [AW-1:0] rd_q  [NREQ];
  logic [CW-1:0] cnt_q [NREQ];
  logic [SW:0]   mem_q [NREQ][FIFO_DEPTH];

  logic          gnt_v;
  logic [IW-1:0] gnt_id;
  logic [IW:0]   scan;
  logic          head_v;
  logic [IW-1:0] head_id;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;

  assign head_v  = tag_v_q[LATENCY-1];
  assign head_id = tag_id_q[LATENCY-1];

  // Scan from the round-robin pointer; a requester needs a free credit to be eligible.
  always_comb begin
    gnt_v     = 1'b0;
    gnt_id    = '0;
    scan      = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!gnt_v && req_valid[scan[IW-1:0]] && (credit_q[scan[IW-1:0]] != '0)) begin
        gnt_v  = 1'b1;
        gnt_id = scan[IW-1:0];
      end
    end
    if (reset) gnt_v = 1'b0;
    if (gnt_v) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    push          = '0;
    pop           = '0;
    rsp_valid     = '0;
    rsp_result    = '0;
    rsp_truncated = '0;
    for (int i = 0; i < NREQ; i++) begin
      push[i]                = head_v && (head_id == IW'(i));
      rsp_valid[i]           = (cnt_q[i] != '0);
      pop[i]                 = rsp_valid[i] && rsp_ready[i];
      rsp_result[i*SW +: SW] = mem_q[i][rd_q[i]][SW-1:0];
      rsp_truncated[i]       = mem_q[i][rd_q[i]][SW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      issue_id_q  <= '0;
      adder_start <= 1'b0;
      adder_in1   <= '0;
      adder_in2   <= '0;
      sched_err   <= 1'b0;
      blank_q     <= BW'(LATENCY);
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= CW'(FIFO_DEPTH);
        wr_q[i]     <= '0;
        rd_q[i]     <= '0;
        cnt_q[i]    <= '0;
      end
      for (int k = 0; k < LATENCY; k++) begin
        tag_v_q[k]  <= 1'b0;
        tag_id_q[k] <= '0;
      end
    end else begin
      adder_start <= gnt_v;
      issue_id_q  <= gnt_id;
      if (gnt_v) begin
        adder_in1 <= req_in1[gnt_id*RW +: RW];
        adder_in2 <= req_in2[gnt_id*RW +: RW];
        ptr_q     <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
      // The issue register is the first stage, so this pipe ends on the adder's result cycle.
      tag_v_q[0]  <= adder_start;
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      // Results from operations issued before reset are still draining out of the adder.
      if (blank_q != '0) blank_q <= blank_q - 1'b1;
      else if (head_v ^ adder_done) sched_err <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) wr_q[i] <= (wr_q[i] == AW'(FIFO_DEPTH-1)) ? '0 : wr_q[i] + 1'b1;
        if (pop[i])  rd_q[i] <= (rd_q[i] == AW'(FIFO_DEPTH-1)) ? '0 : rd_q[i] + 1'b1;
        cnt_q[i]    <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        credit_q[i] <= credit_q[i] + CW'(pop[i]) - CW'(req_ready[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= {adder_truncated, adder_result};
    end
  end

`ifdef POSIT_ARB_STATS_EN
  logic [31:0] stat_q [NREQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) stat_grants[i*32 +: 32] = stat_q[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_posit_add_rr_sched.sv
// Bench for posit_add_rr_sched: a latency-accurate stand-in adder (wrapping sum of the
// raw operands, truncated = both LSBs set), per-requester drivers and a scoreboard.
module tb_posit_add_rr_sched;

  localparam int NREQ   = 4;
  localparam int LAT    = 8;
  localparam int FD     = 4;
  localparam int RW     = 40;
  localparam int SW     = 42;
  localparam int IW     = 2;
  localparam int EW     = IW + 1 + SW;
  localparam int MAXOPS = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*RW-1:0] req_in1;
  logic [NREQ*RW-1:0] req_in2;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*SW-1:0] rsp_result;
  logic [NREQ-1:0]    rsp_truncated;
  logic [RW-1:0]      adder_in1;
  logic [RW-1:0]      adder_in2;
  logic               adder_start;
  logic [SW-1:0]      adder_result;
  logic               adder_done;
  logic               adder_truncated;
  logic               sched_err;
  logic [NREQ*32-1:0] stat_grants;

  posit_add_rr_sched #(
    .NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(FD), .RW(RW), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_truncated(rsp_truncated),
    .adder_in1(adder_in1), .adder_in2(adder_in2), .adder_start(adder_start),
    .adder_result(adder_result), .adder_done(adder_done), .adder_truncated(adder_truncated),
    .sched_err(sched_err), .stat_grants(stat_grants)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stand-in adder ----------------
  logic          done_sr [LAT];
  logic [SW-1:0] res_sr  [LAT];
  logic          tr_sr   [LAT];
  logic          force_done;

  always @(posedge clk) begin
    done_sr[0] <= adder_start;
    res_sr[0]  <= {{(SW-RW){1'b0}}, adder_in1 + adder_in2};
    tr_sr[0]   <= adder_in1[0] & adder_in2[0];
    for (int k = 1; k < LAT; k++) begin
      done_sr[k] <= done_sr[k-1];
      res_sr[k]  <= res_sr[k-1];
      tr_sr[k]   <= tr_sr[k-1];
    end
  end

  assign adder_done      = done_sr[LAT-1] | force_done;
  assign adder_result    = res_sr[LAT-1];
  assign adder_truncated = tr_sr[LAT-1];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  int grant_id_q[$];
  int grant_cyc_q[$];
  int gcount    [NREQ];
  int last_gcyc [NREQ];

  logic [RW-1:0] op_a [NREQ][MAXOPS];
  logic [RW-1:0] op_b [NREQ][MAXOPS];
  logic [SW-1:0] op_s [NREQ][MAXOPS];
  logic          op_t [NREQ][MAXOPS];
  int            n_ops  [NREQ];
  int            op_idx [NREQ];
  logic [NREQ-1:0] drv_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_op(input int id, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic [SW-1:0] s, input logic t);
    if (n_ops[id] < MAXOPS) begin
      op_a[id][n_ops[id]] = a;
      op_b[id][n_ops[id]] = b;
      op_s[id][n_ops[id]] = s;
      op_t[id][n_ops[id]] = t;
      n_ops[id]++;
    end
  endtask

  task automatic sync_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic set_rdy(input logic [NREQ-1:0] m);
    @(posedge clk);
    #1;
    rsp_ready = m;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    grant_id_q.delete();
    grant_cyc_q.delete();
    for (int i = 0; i < NREQ; i++) op_idx[i] = n_ops[i];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      busy = (exp_q.size() != 0);
      for (int i = 0; i < NREQ; i++) if (op_idx[i] < n_ops[i]) busy = 1'b1;
      n++;
    end while (busy && n < 400);
    check(name, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Requester drivers: acceptance is observed mid-cycle, inputs change just after the edge.
  initial begin
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    forever begin
      @(negedge clk);
      drv_acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (drv_acc[i]) begin
          exp_q.push_back({IW'(i), op_t[i][op_idx[i]], op_s[i][op_idx[i]]});
          gcount[i]++;
          grant_id_q.push_back(i);
          grant_cyc_q.push_back(cyc);
          last_gcyc[i] = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (drv_acc[i] && op_idx[i] < n_ops[i]) op_idx[i]++;
        if (op_idx[i] < n_ops[i]) begin
          req_valid[i]          = 1'b1;
          req_in1[i*RW +: RW]   = op_a[i][op_idx[i]];
          req_in2[i*RW +: RW]   = op_b[i][op_idx[i]];
        end else begin
          req_valid[i]          = 1'b0;
          req_in1[i*RW +: RW]   = '0;
          req_in2[i*RW +: RW]   = '0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < NREQ; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            int found;
            found = -1;
            for (int j = 0; j < exp_q.size(); j++)
              if (found < 0 && int'(exp_q[j][EW-1 -: IW]) == i) found = j;
            if (found < 0) begin
              check("rsp_unexpected", 64'(rsp_valid[i]), 64'd0);
            end else begin
              check($sformatf("rsp_data_req%0d", i),
                    64'({rsp_truncated[i], rsp_result[i*SW +: SW]}),
                    64'(exp_q[found][SW:0]));
              exp_q.delete(found);
            end
          end
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int n, b0, b1, b2, b3;
    bit seen_v, seen_e;
    reset      = 1'b1;
    rsp_ready  = '1;
    force_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      n_ops[i] = 0; op_idx[i] = 0; gcount[i] = 0; last_gcyc[i] = 0;
    end
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_adder_start", 64'(adder_start), 64'd0);
    check("rst_adder_in1", 64'(adder_in1), 64'd0);
    check("rst_adder_in2", 64'(adder_in2), 64'd0);
    check("rst_sched_err", 64'(sched_err), 64'd0);
    check("rst_stat", 64'(stat_grants[63:0] | stat_grants[127:64]), 64'd0);

    // Single requester: latency and data
    set_rdy(4'b1110);
    sync_neg();
    load_op(0, 40'h0040000000, 40'h0040000000, 42'h0080000000, 1'b0);
    n = 0;
    while (!rsp_valid[0] && n < 40) begin @(negedge clk); n++; end
    check("t1_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check("t1_latency", 64'(cyc - last_gcyc[0]), 64'(LAT + 2));
    set_rdy(4'b1111);
    wait_idle("t1_drain");

    // All requesters busy: strict rotation, one grant per cycle
    do_reset();
    sync_neg();
    load_op(0, 40'h0000001000, 40'h0000000234, 42'h0000001234, 1'b0);
    load_op(0, 40'h0000000003, 40'h0000000005, 42'h0000000008, 1'b1);
    load_op(0, 40'hFFFFFFFFFF, 40'h0000000001, 42'h0000000000, 1'b1);
    load_op(1, 40'h0000000100, 40'h0000000200, 42'h0000000300, 1'b0);
    load_op(1, 40'h000000007F, 40'h0000000001, 42'h0000000080, 1'b1);
    load_op(1, 40'h0012345678, 40'h0011111111, 42'h0023456789, 1'b0);
    load_op(2, 40'h0040000000, 40'h00C0000000, 42'h0100000000, 1'b0);
    load_op(2, 40'h0000000001, 40'h0000000001, 42'h0000000002, 1'b1);
    load_op(2, 40'h000000AAAA, 40'h0000005555, 42'h000000FFFF, 1'b0);
    load_op(3, 40'h8000000000, 40'h8000000000, 42'h0000000000, 1'b0);
    load_op(3, 40'h000000000F, 40'h00000000F0, 42'h00000000FF, 1'b0);
    load_op(3, 40'h0000000033, 40'h0000000011, 42'h0000000044, 1'b1);
    wait_idle("t2_drain");
    check("t2_grant_count", 64'(grant_id_q.size()), 64'd12);
    for (int k = 0; k < 12 && k < grant_id_q.size(); k++) begin
      check($sformatf("t2_order_%0d", k), 64'(grant_id_q[k]), 64'(k % NREQ));
      check($sformatf("t2_back_to_back_%0d", k), 64'(grant_cyc_q[k] - grant_cyc_q[0]), 64'(k));
    end

    // Credit exhaustion on requester 1 only
    b0 = gcount[0]; b1 = gcount[1]; b2 = gcount[2]; b3 = gcount[3];
    set_rdy(4'b1101);
    sync_neg();
    for (int k = 0; k < 6; k++) load_op(1, 40'h0048000000, 40'hFFB8000000, 42'h0, 1'b0);
    load_op(0, 40'h0000000021, 40'h0000000021, 42'h0000000042, 1'b1);
    load_op(0, 40'h0000000100, 40'h0000000001, 42'h0000000101, 1'b0);
    load_op(2, 40'h0000000005, 40'h0000000006, 42'h000000000B, 1'b0);
    load_op(2, 40'h0000000007, 40'h0000000009, 42'h0000000010, 1'b1);
    load_op(3, 40'h0000000010, 40'h0000000020, 42'h0000000030, 1'b0);
    load_op(3, 40'h0000000002, 40'h0000000003, 42'h0000000005, 1'b0);
    repeat (30) @(negedge clk);
    check("t3_req1_grants", 64'(gcount[1] - b1), 64'd4);
    check("t3_req1_pending", 64'(req_valid[1]), 64'd1);
    check("t3_req1_blocked", 64'(req_ready[1]), 64'd0);
    check("t3_req0_grants", 64'(gcount[0] - b0), 64'd2);
    check("t3_req2_grants", 64'(gcount[2] - b2), 64'd2);
    check("t3_req3_grants", 64'(gcount[3] - b3), 64'd2);
    set_rdy(4'b1111);
    set_rdy(4'b1101);
    repeat (12) @(negedge clk);
    check("t3_req1_after_pop", 64'(gcount[1] - b1), 64'd5);
    set_rdy(4'b1111);
    wait_idle("t3_drain");

    // Spurious adder_done
    check("t4_err_before", 64'(sched_err), 64'd0);
    @(posedge clk); #1; force_done = 1'b1;
    @(posedge clk); #1; force_done = 1'b0;
    @(negedge clk);
    check("t4_err_set", 64'(sched_err), 64'd1);
    check("t4_no_push", 64'(rsp_valid), 64'd0);
    do_reset();
    @(negedge clk);
    check("t4_err_cleared", 64'(sched_err), 64'd0);

    // Reset with operations in flight
    sync_neg();
    load_op(0, 40'h1, 40'h1, 42'h2, 1'b1);
    load_op(0, 40'h1, 40'h1, 42'h2, 1'b1);
    load_op(1, 40'h2, 40'h2, 42'h4, 1'b0);
    load_op(1, 40'h2, 40'h2, 42'h4, 1'b0);
    load_op(2, 40'h3, 40'h3, 42'h6, 1'b1);
    n = 0;
    while (grant_id_q.size() < 5 && n < 50) begin @(negedge clk); n++; end
    check("t5_pre_grants", 64'(grant_id_q.size()), 64'd5);
    do_reset();
    seen_v = 1'b0;
    seen_e = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (rsp_valid != '0) seen_v = 1'b1;
      if (sched_err) seen_e = 1'b1;
    end
    check("t5_rsp_quiet", 64'(seen_v), 64'd0);
    check("t5_err_quiet", 64'(seen_e), 64'd0);
    b1 = gcount[1]; b2 = gcount[2];
    set_rdy(4'b0000);
    sync_neg();
    for (int k = 0; k < 5; k++) load_op(2, 40'h40, 40'h40, 42'h80, 1'b0);
    load_op(1, 40'h11, 40'h22, 42'h33, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_first_grant", 64'((grant_id_q.size() > 0) ? grant_id_q[0] : 99), 64'd1);
    check("t5_req2_credits", 64'(gcount[2] - b2), 64'd4);
    check("t5_req1_grants", 64'(gcount[1] - b1), 64'd1);
    set_rdy(4'b1111);
    wait_idle("t5_drain");

    // Grant statistics
    sync_neg();
    for (int k = 0; k < 5; k++) load_op(2, 40'h0A, 40'h05, 42'h0F, 1'b0);
    wait_idle("t6_drain");
`ifdef POSIT_ARB_STATS_EN
    check("t6_stat_req2", 64'(stat_grants[2*32 +: 32]), 64'd10);
    check("t6_stat_req1", 64'(stat_grants[1*32 +: 32]), 64'd1);
`else
    check("t6_stat_req2", 64'(stat_grants[2*32 +: 32]), 64'd0);
    check("t6_stat_req1", 64'(stat_grants[1*32 +: 32]), 64'd0);
`endif
    check("end_sched_err", 64'(sched_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
